classificador_peso_n: RTL
=========================

Name: classificador_peso_n

Overview:
- Parametrised successor of the weight-sorting datapath's fixed-field command register and comparator.
- Consumes the byte stream from the UART receiver and parses ASCII-decimal frames of configurable digit count.
- Holds NBINS programmable upper limits and classifies each weight by a sequential scan of those limits.
- Emits a bin index for the servo position mux; weights above every limit go to a reject bin.

Parameters:
- DIGITS, 4, ASCII digits per numeric field
- NBINS, 4, number of programmable bins (2..9)
- W, 16, width of weight and limit values; must satisfy 10^DIGITS-1 < 2^W
- BW, $clog2(NBINS+1), derived width of the bin index; not overridable

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: rx_byte valid
- rx_byte  in  8  received ASCII byte
- res_valid  out  1  one-cycle pulse: classification result valid
- res_bin  out  BW  bin index 0..NBINS-1, or NBINS = reject
- res_peso  out  W  binary weight that was classified
- busy  out  1  high from frame start through DONE
- erro  out  1  one-cycle pulse on protocol error or dropped byte

Behaviour:
- Reset (reset=0, async) clears the following:
  - state=IDLE, all limits=0, accumulator, digit counter and scan index=0
  - res_valid=0, res_bin=0, res_peso=0, busy=0, erro=0
- Reset mid-frame or mid-scan aborts with no result.
- Frame formats:
  - Weight frame: '#'(0x23) followed by DIGITS digits '0'..'9'.
  - Limit frame: 'L'(0x4C), one index digit k, then DIGITS digits; writes limit[k].
- Digit conversion: acc <= acc*10 + (rx_byte-0x30), computed in W bits. Leading zeros are mandatory; there is no terminator.
- States and transitions:
  - IDLE: '#' -> GET_W with acc=0, cnt=0. 'L' -> GET_IDX. Other bytes (CR, LF, etc.) are ignored silently with no erro.
  - GET_IDX: digit with value < NBINS -> latch k, go GET_L. Otherwise pulse erro and go IDLE.
  - GET_W and GET_L: each digit increments cnt. On the DIGITS-th digit:
    - GET_W latches res_peso <= final acc and goes SCAN with idx=0.
    - GET_L writes limit[k] <= final acc on that same edge and goes IDLE. It produces no res_valid.
  - In any GET_* state:
    - '#' or 'L' pulses erro and restarts the corresponding new frame.
    - Any other non-digit pulses erro and goes IDLE.
  - SCAN: one limit per cycle. If res_peso <= limit[idx], set res_bin=idx and go DONE. Else if idx==NBINS-1, set res_bin=NBINS and go DONE. Else idx++.
  - DONE: res_valid=1 for exactly one cycle, then IDLE.
- busy is high in every state except IDLE.
- Bytes arriving with rx_valid in SCAN or DONE are dropped and pulse erro. The result is unaffected.
- Latency: let the last weight digit be accepted at edge t.
  - Bin k: res_valid is high in the cycle after edge t+k+1, i.e. k+2 cycles.
  - Reject: NBINS+1 cycles.
- Limits are not required to be ascending. The first matching index (lowest k) wins.
- Ties: weight == limit matches, same as the inclusive <= comparison.
- res_bin and res_peso hold their values until the next result.
- erro and res_valid can never assert in the same cycle.

Decomposition:
- Shared package (pkg_classificador) holds:
  - ASCII constants: CH_HASH=8'h23, CH_L=8'h4C, CH_0=8'h30, CH_9=8'h39
  - the state enum: IDLE, GET_W, GET_IDX, GET_L, SCAN, DONE
- One sub-module: ascii_dec_acc_n. It is the W-bit x10 accumulator with a digit-valid flag and a clear input, so it can be reused by other frame parsers.
- The limit array and scan logic stay in the top module.

Test Plan:
- Default parameters, after reset send "#0000" -> res_valid with res_bin=0 and res_peso=0, because the 0 <= 0 match hits bin 0. Send "#0005" -> res_bin=4 (reject).
- Send "L00100","L10200","L20300","L30400" then "#0250" -> res_bin=2 and res_peso=250, with res_valid exactly 4 cycles after the last digit edge.
- Same limits, send "#0400" -> bin 3 (tie). Send "#0401" -> bin 4 (reject) after 5 cycles.
- Send "#02x" -> erro pulse and no res_valid. Send "#01#0150" -> one erro, then result bin 1.
- Send "L7..." with NBINS=4 -> erro and limits unchanged. Send a byte during SCAN -> erro, and the scan result is still correct.
- Drive reset low mid-SCAN -> all outputs 0 immediately, limits cleared. A following "#0001" -> bin 4.

Source files
------------

// File: rtl/classificador_peso_n_pkg.sv
// Shared constants and state encoding for the weight classifier frame parser.
package pkg_classificador;

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_L    = 8'h4C;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  typedef enum logic [2:0] {
    IDLE,
    GET_W,
    GET_IDX,
    GET_L,
    SCAN,
    DONE
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/classificador_peso_n_acc.sv
// W-bit decimal accumulator: value = value*10 + digit, truncated to W bits.
// value_next is exposed so a parser can capture the final field on the last digit's edge.
module ascii_dec_acc_n #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         digit_valid,
  input  logic [3:0]   digit,
  output logic [W-1:0] value_next
);

  logic [W-1:0] acc;

  assign value_next = W'(acc * W'(10)) + W'(digit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (digit_valid) begin
      acc <= value_next;
    end
  end

endmodule

// File: rtl/classificador_peso_n.sv
// Parses '#'-weight and 'L'-limit ASCII frames, then classifies each weight by a
// sequential scan of NBINS programmable upper limits (first inclusive match wins).
module classificador_peso_n
  import pkg_classificador::*;
#(
  parameter int DIGITS = 4,
  parameter int NBINS  = 4,
  parameter int W      = 16,
  localparam int BW    = $clog2(NBINS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          res_valid,
  output logic [BW-1:0] res_bin,
  output logic [W-1:0]  res_peso,
  output logic          busy,
  output logic          erro
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int IW = $clog2(NBINS);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] k;
  logic [W-1:0]  limits [NBINS];
  logic          erro_pend;

  logic          byte_is_digit;
  logic [3:0]    digit_val;
  logic          digit_valid;
  logic          acc_clear;
  logic          last_digit;
  logic          scan_match;
  logic          scan_last;
  logic [W-1:0]  acc_next;

  // ASCII '0'..'9' carry their value in the low nibble.
  assign digit_val     = rx_byte[3:0];
  assign byte_is_digit = is_digit(rx_byte);
  assign digit_valid   = rx_valid && byte_is_digit && (state == GET_W || state == GET_L);
  assign acc_clear     = rx_valid && !digit_valid;
  assign last_digit    = digit_valid && (cnt == CW'(DIGITS - 1));
  assign scan_match    = res_peso <= limits[idx];
  assign scan_last     = idx == IW'(NBINS - 1);
  assign busy          = state != IDLE;

  ascii_dec_acc_n #(.W(W)) u_acc (
    .clock       (clock),
    .reset       (reset),
    .clear       (acc_clear),
    .digit_valid (digit_valid),
    .digit       (digit_val),
    .value_next  (acc_next)
  );

  // A byte dropped on the edge entering DONE would collide with res_valid, so its
  // erro pulse is deferred by one cycle through erro_pend.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      k         <= '0;
      erro_pend <= 1'b0;
      res_valid <= 1'b0;
      res_bin   <= '0;
      res_peso  <= '0;
      erro      <= 1'b0;
      for (int i = 0; i < NBINS; i++) begin
        limits[i] <= '0;
      end
    end else begin
      res_valid <= 1'b0;
      erro      <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_byte == CH_HASH) begin
              state <= GET_W;
              cnt   <= '0;
            end else if (rx_byte == CH_L) begin
              state <= GET_IDX;
            end
          end
        end

        GET_IDX: begin
          if (rx_valid) begin
            if (rx_byte == CH_HASH) begin
              erro  <= 1'b1;
              state <= GET_W;
              cnt   <= '0;
            end else if (rx_byte == CH_L) begin
              erro  <= 1'b1;
              state <= GET_IDX;
            end else if (byte_is_digit && (int'(digit_val) < NBINS)) begin
              k     <= IW'(digit_val);
              cnt   <= '0;
              state <= GET_L;
            end else begin
              erro  <= 1'b1;
              state <= IDLE;
            end
          end
        end

        GET_W, GET_L: begin
          if (rx_valid) begin
            if (byte_is_digit) begin
              cnt <= cnt + CW'(1);
              if (last_digit) begin
                if (state == GET_W) begin
                  res_peso <= acc_next;
                  idx      <= '0;
                  state    <= SCAN;
                end else begin
                  limits[k] <= acc_next;
                  state     <= IDLE;
                end
              end
            end else if (rx_byte == CH_HASH) begin
              erro  <= 1'b1;
              state <= GET_W;
              cnt   <= '0;
            end else if (rx_byte == CH_L) begin
              erro  <= 1'b1;
              state <= GET_IDX;
            end else begin
              erro  <= 1'b1;
              state <= IDLE;
            end
          end
        end

        SCAN: begin
          if (scan_match) begin
            res_bin   <= BW'(idx);
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (scan_last) begin
            res_bin   <= BW'(NBINS);
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
          if (rx_valid) begin
            if (scan_match || scan_last) begin
              erro_pend <= 1'b1;
            end else begin
              erro <= 1'b1;
            end
          end
        end

        DONE: begin
          erro      <= rx_valid || erro_pend;
          erro_pend <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
